// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - arbiter PUF challenge sequencer with majority-voted response assembly
//
// Drives the mux-select challenge and the race launch edge of an arbiter PUF.
// It samples the synchronised arbiter decision once per evaluation and
// majority-votes N_EVAL evaluations into each of N_BITS response bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, only honoured in IDLE
//   chal_base  first challenge of a run, latched on an accepted start
//   arb_in     raw arbiter decision, asynchronous to clk
//   chal       challenge onto the mux select lines
//   launch     race edge into the head of the delay chain
//   busy       high whenever the sequencer is not idle
//   resp       response word, bit i from challenge i of the run
//   valid      one-cycle pulse when resp/stable carry a finished run
//   stable     every evaluation of every bit of the last run was unanimous

module puf_challenge_sequencer #(
    parameter int CHAL_W = 4,
    parameter int N_BITS = 8,
    parameter int N_EVAL = 7,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_base,
    input  logic              arb_in,
    output logic [CHAL_W-1:0] chal,
    output logic              launch,
    output logic              busy,
    output logic [N_BITS-1:0] resp,
    output logic              valid,
    output logic              stable
);

    localparam int ONES_W = $clog2(N_EVAL + 1);
    localparam int EVAL_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
    localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SET_W  = $clog2(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RACE,
        SAMPLE,
        DONE
    } state_t;

    state_t            state;
    logic              arb_s1;
    logic              arb_s;
    logic [ONES_W-1:0] ones;
    logic [EVAL_W-1:0] eval_idx;
    logic [BIT_W-1:0]  bit_idx;
    logic [SET_W-1:0]  phase_cnt;
    logic              first_eval;
    logic              disagree;

    logic [ONES_W-1:0] ones_next;
    logic              mismatch;
    logic              last_eval;
    logic              last_bit;
    logic              phase_end;

    // The arbiter output resolves at an arbitrary time relative to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_s1 <= 1'b0;
            arb_s  <= 1'b0;
        end else begin
            arb_s1 <= arb_in;
            arb_s  <= arb_s1;
        end
    end

    // ones_next already includes the sample being taken this cycle, so the
    // vote on the final evaluation sees every evaluation of the bit.
    assign ones_next = ones + ONES_W'(arb_s);
    // The first evaluation of each bit is the reference for unanimity.
    assign mismatch  = (eval_idx != '0) && (arb_s != first_eval);
    assign last_eval = (eval_idx == EVAL_W'(N_EVAL - 1));
    assign last_bit  = (bit_idx == BIT_W'(N_BITS - 1));
    assign phase_end = (phase_cnt == SET_W'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            chal       <= '0;
            launch     <= 1'b0;
            busy       <= 1'b0;
            resp       <= '0;
            valid      <= 1'b0;
            stable     <= 1'b0;
            ones       <= '0;
            eval_idx   <= '0;
            bit_idx    <= '0;
            phase_cnt  <= '0;
            first_eval <= 1'b0;
            disagree   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        chal      <= chal_base;
                        bit_idx   <= '0;
                        eval_idx  <= '0;
                        ones      <= '0;
                        disagree  <= 1'b0;
                        phase_cnt <= '0;
                        launch    <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        launch    <= 1'b1;
                        state     <= RACE;
                    end else begin
                        phase_cnt <= phase_cnt + SET_W'(1);
                    end
                end
                RACE: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        state     <= SAMPLE;
                    end else begin
                        phase_cnt <= phase_cnt + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    launch <= 1'b0;
                    if (eval_idx == '0) begin
                        first_eval <= arb_s;
                    end
                    if (mismatch) begin
                        disagree <= 1'b1;
                    end
                    if (!last_eval) begin
                        ones     <= ones_next;
                        eval_idx <= eval_idx + EVAL_W'(1);
                        state    <= SETUP;
                    end else begin
                        // Bits of the run in progress update in place.
                        resp[bit_idx] <= (ones_next > ONES_W'(N_EVAL / 2));
                        ones          <= '0;
                        eval_idx      <= '0;
                        chal          <= chal + CHAL_W'(1);
                        if (last_bit) begin
                            valid  <= 1'b1;
                            stable <= ~(disagree | mismatch);
                            state  <= DONE;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            state   <= SETUP;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - scoreboard bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

    // VALID lands in cycle 393 after the start edge, i.e. 392 edges later.
    localparam int VALID_EDGE = 392;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] chal_base;
    logic       arb_in;
    logic [3:0] chal;
    logic       launch;
    logic       busy;
    logic [7:0] resp;
    logic       valid;
    logic       stable;

    typedef struct {
        logic [7:0] resp;
        logic       stable;
        int         edge_n;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] chal_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int ec     = 0;
    int mode   = 0;
    int k_ones = 0;
    int eval_in_run = 0;
    int start_edge  = 0;

    // Monitor state
    int         lo = 0;
    int         hi = 0;
    logic [3:0] chal_ref = '0;
    logic       moved = 1'b0;
    logic       busy_chk = 1'b0;

    // Arbiter model: 0 tied high, 1 follows chal[0], 2 high for the first k evals of each bit.
    assign arb_in = (mode == 0) ? 1'b1 :
                    (mode == 1) ? chal[0] :
                    ((eval_in_run % 7) < k_ones);

    puf_challenge_sequencer #(
        .CHAL_W(4),
        .N_BITS(8),
        .N_EVAL(7),
        .SETTLE(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .chal_base(chal_base),
        .arb_in   (arb_in),
        .chal     (chal),
        .launch   (launch),
        .busy     (busy),
        .resp     (resp),
        .valid    (valid),
        .stable   (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ec <= ec + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic end_eval();
        check("race_len", hi, 4);
        check("chal_stable", moved, 0);
        if ((eval_in_run % 7) == 6 && chal_q.size() > 0) begin
            check("chal_seq", chal_ref, chal_q.pop_front());
        end
        eval_in_run++;
        hi = 0;
    endtask

    // Monitor: phase timing, challenge sequence and scoreboard pop on valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            lo = 0;
            hi = 0;
            eval_in_run = 0;
            moved = 1'b0;
            busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                check("busy_after_valid", busy, 0);
                busy_chk = 1'b0;
            end
            if (valid) begin
                if (hi != 0) end_eval();
                lo = 0;
                hi = 0;
                if (sb.size() == 0) begin
                    check("spurious_valid", valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("valid_edge", ec, e.edge_n);
                    check("resp", resp, e.resp);
                    check("stable", stable, e.stable);
                    busy_chk = 1'b1;
                end
            end else if (busy) begin
                if (!launch) begin
                    if (hi != 0) end_eval();
                    if (lo == 0) begin
                        chal_ref = chal;
                        moved = 1'b0;
                    end else if (chal != chal_ref) begin
                        moved = 1'b1;
                    end
                    lo++;
                end else begin
                    if (lo != 0) begin
                        check("setup_len", lo, 3);
                        lo = 0;
                    end
                    if (chal != chal_ref) moved = 1'b1;
                    hi++;
                end
            end else begin
                lo = 0;
                hi = 0;
                eval_in_run = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] base, input logic [7:0] r, input logic s, input bit push);
        @(negedge clk);
        start = 1'b1;
        chal_base = base;
        @(posedge clk);
        #1;
        start_edge = ec;
        if (push) begin
            exp_t e;
            e.resp = r;
            e.stable = s;
            e.edge_n = start_edge + VALID_EDGE;
            sb.push_back(e);
            for (int i = 0; i < 8; i++) chal_q.push_back(base + 4'(i));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        chal_base = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_chal", chal, 0);
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_resp", resp, 0);
        check("rst_valid", valid, 0);
        check("rst_stable", stable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tied high; start pulses at cycles 50, 392 and 393 (DONE) are ignored.
        mode = 0;
        issue(4'h3, 8'hFF, 1'b1, 1'b1);
        repeat (49) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (341) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("no_second_run", busy, 0);

        // Arbiter follows chal[0]; challenge wraps F->0.
        mode = 1;
        issue(4'hE, 8'hAA, 1'b1, 1'b1);
        wait_idle();

        // Majority 4 of 7 and 3 of 7.
        mode = 2;
        k_ones = 4;
        issue(4'h0, 8'hFF, 1'b0, 1'b1);
        wait_idle();
        k_ones = 3;
        issue(4'h5, 8'h00, 1'b0, 1'b1);
        wait_idle();

        // Abort at cycle 120: two bits already resolved in place.
        mode = 0;
        issue(4'h7, 8'h00, 1'b0, 1'b0);
        repeat (118) @(posedge clk);
        #2;
        check("partial_resp", resp, 8'h03);
        rst_n = 1'b0;
        #1;
        check("abort_chal", chal, 0);
        check("abort_launch", launch, 0);
        check("abort_busy", busy, 0);
        check("abort_resp", resp, 0);
        check("abort_valid", valid, 0);
        check("abort_stable", stable, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full run after the abort: chal 3..A, odd challenges give 1.
        mode = 1;
        issue(4'h3, 8'h55, 1'b1, 1'b1);
        wait_idle();

        check("sb_drained", sb.size(), 0);
        check("chal_q_drained", chal_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Controller that sits directly upstream and downstream of the 16:1 mux delay-chain stages of the arbiter PUF. It drives the mux select lines (challenge) and the race launch edge. It samples the arbiter decision and majority-votes repeated evaluations into one response bit per challenge. A full run assembles an N_BITS response word, a VALID pulse and a stability flag.

Parameters:
CHAL_W, 4, challenge width driven onto the mux select lines (S0..S3 of each stage).
N_BITS, 8, response bits per run; one challenge per bit.
N_EVAL, 7, evaluations per challenge; odd, at least 1.
SETTLE, 3, cycles per setup phase and per race phase; at least 3.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  reset, asynchronous assert, active-low.
START  in  1  run request; sampled only in IDLE.
CHAL_BASE  in  CHAL_W  first challenge of the run; latched on accepted START.
ARB_IN  in  1  raw arbiter output; asynchronous to CLK.
CHAL  out  CHAL_W  challenge to the mux select lines.
LAUNCH  out  1  race edge into the head of the delay chain.
BUSY  out  1  high whenever the FSM is not in IDLE.
RESP  out  N_BITS  response word; bit i comes from challenge i.
VALID  out  1  one-cycle pulse when RESP and STABLE are updated.
STABLE  out  1  1 when every evaluation of every bit in the last run was unanimous.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE. CHAL, LAUNCH, BUSY, RESP, VALID, STABLE, all counters and both sync flops = 0.
- ARB_IN passes through a 2-flop synchronizer. Only the synchronized value (arb_s) is used.
- All outputs are registered.
- FSM states: IDLE, SETUP, RACE, SAMPLE, DONE.
- IDLE: START=1 latches CHAL_BASE into CHAL and clears bit_idx, eval_idx, ones and the unanimity flag. Next state is SETUP. START=0 stays in IDLE.
- SETUP: LAUNCH=0 for exactly SETTLE cycles, with CHAL held stable. Then go to RACE.
- RACE: LAUNCH=1 for exactly SETTLE cycles, with CHAL held stable. Then go to SAMPLE.
- SAMPLE (1 cycle): LAUNCH=1. If arb_s=1, ones increments. The unanimity flag records any disagreement with the first evaluation of the bit.
  - If eval_idx < N_EVAL-1: eval_idx increments and the FSM goes to SETUP.
  - Otherwise: RESP[bit_idx] = (ones_final > N_EVAL/2), where ones_final includes the current sample. ones and eval_idx clear. CHAL increments, wrapping mod 2^CHAL_W (e.g. F->0).
  - If bit_idx = N_BITS-1, go to DONE; otherwise bit_idx increments and the FSM goes to SETUP.
- DONE (1 cycle): VALID=1, STABLE updated, LAUNCH=0. Then go to IDLE.
- Each evaluation takes 2*SETTLE+1 cycles. LAUNCH is low for SETTLE cycles, then high for SETTLE+1 cycles.
- Latency: if START is sampled at edge 0, VALID is high in cycle N_BITS*N_EVAL*(2*SETTLE+1)+1. For the default parameters that is cycle 393.
- RESP and STABLE hold their values from DONE until the next DONE or reset. RESP bits of the run in progress update in place.
- START while BUSY is ignored; no queuing.
- RST_N low mid-run aborts immediately to the reset state. The partial response is discarded (RESP=0).
- START in the DONE cycle is ignored. It is accepted on the following IDLE cycle.
- ones counter width is clog2(N_EVAL+1). Counters never overflow.

Test Plan:
- ARB_IN tied 1, CHAL_BASE=4'h3, defaults -> VALID exactly at cycle 393, RESP=8'hFF, STABLE=1, BUSY low the cycle after VALID.
- ARB_IN = CHAL[0] during RACE, CHAL_BASE=4'hE -> CHAL sequence E,F,0,1,2,3,4,5 (wrap checked), RESP=8'hAA, STABLE=1.
- Majority vote: ARB_IN=1 for 4 of 7 evals of every bit -> RESP=8'hFF, STABLE=0. Repeat with 3 of 7 -> RESP=8'h00, STABLE=0.
- Phase timing: check every evaluation has LAUNCH=0 for 3 cycles, then 1 for 4 cycles, with CHAL unchanged across all 7 cycles.
- START pulsed at cycles 50 and 392 during a run -> ignored: exactly one VALID, at cycle 393, and no second run starts.
- RST_N low at cycle 120 mid-run -> all outputs 0 asynchronously. A new START after release gives full-length latency and a correct RESP.
